mem_arbiter: RTL and testbench

Two-requester, single-port memory arbiter for the RV32 core. It shares one memory bus between the instruction fetch path (IFU) and the load/store path (LSU). The arbiter keeps exactly one transaction in flight and grants round-robin when both requesters are active. It sits between the core's fetch/LSU logic and the memory model or bus bridge.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) single-port memory arbiter with one transaction in flight.
// Round-robin on ties; all memory-side and response outputs are registered.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
    output logic                    ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rsp_data,

    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
    input  logic                    lsu_req_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
    output logic                    lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rsp_data,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic                    mem_req_wen,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
    typedef enum logic {SRC_IFU, SRC_LSU} src_t;

    state_t                    r_state;
    src_t                      r_owner;
    src_t                      r_last_grant;
    logic                      r_mem_req_valid;
    logic [ADDR_WIDTH-1:0]     r_mem_req_addr;
    logic                      r_mem_req_wen;
    logic [DATA_WIDTH-1:0]     r_mem_req_wdata;
    logic [DATA_WIDTH/8-1:0]   r_mem_req_wmask;
    logic                      r_ifu_rsp_valid;
    logic [DATA_WIDTH-1:0]     r_ifu_rsp_data;
    logic                      r_lsu_rsp_valid;
    logic [DATA_WIDTH-1:0]     r_lsu_rsp_data;

    logic w_idle;
    logic w_ifu_win;
    logic w_lsu_win;

    // On a tie the requester that did not win last time gets the bus.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_ifu_win = w_idle && ifu_req_valid && (!lsu_req_valid || r_last_grant == SRC_LSU);
    assign w_lsu_win = w_idle && lsu_req_valid && (!ifu_req_valid || r_last_grant == SRC_IFU);

    assign ifu_req_ready = w_ifu_win;
    assign lsu_req_ready = w_lsu_win;

    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wen   = r_mem_req_wen;
    assign mem_req_wdata = r_mem_req_wdata;
    assign mem_req_wmask = r_mem_req_wmask;
    assign ifu_rsp_valid = r_ifu_rsp_valid;
    assign ifu_rsp_data  = r_ifu_rsp_data;
    assign lsu_rsp_valid = r_lsu_rsp_valid;
    assign lsu_rsp_data  = r_lsu_rsp_data;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_owner         <= SRC_IFU;
            r_last_grant    <= SRC_LSU;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wen   <= 1'b0;
            r_mem_req_wdata <= '0;
            r_mem_req_wmask <= '0;
            r_ifu_rsp_valid <= 1'b0;
            r_ifu_rsp_data  <= '0;
            r_lsu_rsp_valid <= 1'b0;
            r_lsu_rsp_data  <= '0;
        end else begin
            r_ifu_rsp_valid <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ifu_win) begin
                        r_mem_req_addr  <= ifu_req_addr;
                        r_mem_req_wen   <= 1'b0;
                        r_mem_req_wdata <= '0;
                        r_mem_req_wmask <= '0;
                        r_owner         <= SRC_IFU;
                        r_last_grant    <= SRC_IFU;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ST_REQ;
                    end else if (w_lsu_win) begin
                        r_mem_req_addr  <= lsu_req_addr;
                        r_mem_req_wen   <= lsu_req_wen;
                        r_mem_req_wdata <= lsu_req_wdata;
                        r_mem_req_wmask <= lsu_req_wmask;
                        r_owner         <= SRC_LSU;
                        r_last_grant    <= SRC_LSU;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Responses outside this state are stray and never reach a requester.
                    if (mem_rsp_valid) begin
                        if (r_owner == SRC_IFU) begin
                            r_ifu_rsp_data  <= mem_rsp_data;
                            r_ifu_rsp_valid <= 1'b1;
                        end else begin
                            r_lsu_rsp_data  <= mem_rsp_data;
                            r_lsu_rsp_valid <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-schedule reference model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 1'b0;
        ifu_req_addr  = '0;
        lsu_req_valid = 1'b0;
        lsu_req_addr  = '0;
        lsu_req_wen   = 1'b0;
        lsu_req_wdata = '0;
        lsu_req_wmask = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_req_addr: got %h expected 0", mem_req_addr); end
        checks++; if ({mem_req_wen, mem_req_wdata, mem_req_wmask} !== 37'h0) begin errors++; $display("FAIL reset_mem_req_fields: got wen=%b wdata=%h wmask=%h expected all 0", mem_req_wen, mem_req_wdata, mem_req_wmask); end
        checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got ifu=%b lsu=%b expected 0 0", ifu_rsp_valid, lsu_rsp_valid); end
        checks++; if ({ifu_rsp_data, lsu_rsp_data} !== 64'h0) begin errors++; $display("FAIL reset_rsp_data: got ifu=%h lsu=%h expected 0 0", ifu_rsp_data, lsu_rsp_data); end
        #1;
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready_no_req: got ifu=%b lsu=%b expected 0 0", ifu_req_ready, lsu_req_ready); end
    endtask

    task automatic test_single_fetch();
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL fetch_grant_ready: got ifu=%b lsu=%b expected 1 0", ifu_req_ready, lsu_req_ready); end
        tick();
        ifu_req_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL fetch_mem_req_T1: got valid=%b addr=%h expected 1 80000000", mem_req_valid, mem_req_addr); end
        checks++; if ({mem_req_wen, mem_req_wdata, mem_req_wmask} !== 37'h0) begin errors++; $display("FAIL fetch_ifu_fields_zero: got wen=%b wdata=%h wmask=%h expected all 0", mem_req_wen, mem_req_wdata, mem_req_wmask); end
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0413;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_mem_req_drop_T2: got %b expected 0", mem_req_valid); end
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h0000_0413) begin errors++; $display("FAIL fetch_rsp_T3: got valid=%b data=%h expected 1 00000413", ifu_rsp_valid, ifu_rsp_data); end
        checks++; if (lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_lsu_quiet: got %b expected 0", lsu_rsp_valid); end
        tick();
        checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_rsp_single_pulse: got %b expected 0", ifu_rsp_valid); end
    endtask

    // Both requesters always valid, zero-wait memory: grants every 3 cycles, alternating.
    task automatic test_round_robin();
        int  k;
        int  ph;
        bit  own_lsu;
        logic [31:0] e_addr;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            k  = c / 3;
            ph = c % 3;
            if (ph == 0 && c > 0) begin
                own_lsu = ((k - 1) % 2) == 1;
                checks++; if (ifu_rsp_valid !== !own_lsu || lsu_rsp_valid !== own_lsu) begin errors++; $display("FAIL rr_pulse_owner c=%0d: got ifu=%b lsu=%b expected ifu=%b lsu=%b", c, ifu_rsp_valid, lsu_rsp_valid, !own_lsu, own_lsu); end
                checks++; if ((own_lsu ? lsu_rsp_data : ifu_rsp_data) !== 32'hA000_0000 + 32'(c - 1)) begin errors++; $display("FAIL rr_pulse_data c=%0d: got %h expected %h", c, own_lsu ? lsu_rsp_data : ifu_rsp_data, 32'hA000_0000 + 32'(c - 1)); end
            end else begin
                checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin errors++; $display("FAIL rr_no_pulse c=%0d: got ifu=%b lsu=%b expected 0 0", c, ifu_rsp_valid, lsu_rsp_valid); end
            end
            if (ph == 1) begin
                own_lsu = (k % 2) == 1;
                e_addr  = own_lsu ? 32'h2000 + 32'((c - 1) * 4) : 32'h1000 + 32'((c - 1) * 4);
                checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== e_addr) begin errors++; $display("FAIL rr_mem_req c=%0d: got valid=%b addr=%h expected 1 %h", c, mem_req_valid, mem_req_addr, e_addr); end
                checks++; if (mem_req_wen !== own_lsu || mem_req_wdata !== (own_lsu ? 32'hCAFE_0000 + 32'(c - 1) : 32'h0) || mem_req_wmask !== (own_lsu ? 4'hF : 4'h0)) begin errors++; $display("FAIL rr_mem_fields c=%0d: got wen=%b wdata=%h wmask=%h", c, mem_req_wen, mem_req_wdata, mem_req_wmask); end
            end
            ifu_req_valid = 1'b1;
            ifu_req_addr  = 32'h1000 + 32'(c * 4);
            lsu_req_valid = 1'b1;
            lsu_req_addr  = 32'h2000 + 32'(c * 4);
            lsu_req_wen   = 1'b1;
            lsu_req_wdata = 32'hCAFE_0000 + 32'(c);
            lsu_req_wmask = 4'hF;
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hA000_0000 + 32'(c);
            #1;
            own_lsu = (k % 2) == 1;
            checks++; if (ifu_req_ready !== (ph == 0 && !own_lsu) || lsu_req_ready !== (ph == 0 && own_lsu)) begin errors++; $display("FAIL rr_ready c=%0d: got ifu=%b lsu=%b", c, ifu_req_ready, lsu_req_ready); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_store();
        int pulses = 0;
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_1000;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF;
        lsu_req_wmask = 4'b0011;
        #1;
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL store_ready: got ifu=%b lsu=%b expected 0 1", ifu_req_ready, lsu_req_ready); end
        tick();
        clear_inputs();
        checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin errors++; $display("FAIL store_fields: got valid=%b addr=%h wen=%b wdata=%h wmask=%b", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lsu_rsp_valid === 1'b1) pulses++;
            if (ifu_rsp_valid !== 1'b0) pulses += 100;
            tick();
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL store_ack_once: got %0d pulses expected 1", pulses); end
    endtask

    task automatic test_stalls();
        int pulses = 0;
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_2000;
        lsu_req_wen   = 1'b0;
        #1;
        checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL stall_grant: got %b expected 1", lsu_req_ready); end
        tick();
        ifu_req_valid = 1'b1;
        lsu_req_addr  = 32'h1234_5678;
        lsu_req_wen   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_req_ready = (i == 4);
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_2000 || mem_req_wen !== 1'b0) begin errors++; $display("FAIL stall_req_stable i=%0d: got valid=%b addr=%h wen=%b", i, mem_req_valid, mem_req_addr, mem_req_wen); end
            #1;
            checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready_req i=%0d: got ifu=%b lsu=%b expected 0 0", i, ifu_req_ready, lsu_req_ready); end
            tick();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = (i == 3);
            mem_rsp_data  = 32'h5A5A_1234;
            checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h8000_2000 || {ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin errors++; $display("FAIL stall_resp_wait i=%0d: got valid=%b addr=%h pulses=%b%b", i, mem_req_valid, mem_req_addr, ifu_rsp_valid, lsu_rsp_valid); end
            #1;
            checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready_resp i=%0d: got ifu=%b lsu=%b expected 0 0", i, ifu_req_ready, lsu_req_ready); end
            tick();
        end
        mem_rsp_valid = 1'b0;
        checks++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_data !== 32'h5A5A_1234 || ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_rsp: got lsu=%b data=%h ifu=%b expected 1 5a5a1234 0", lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid); end
        #1;
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL stall_back_to_back: got ifu=%b lsu=%b expected 1 0", ifu_req_ready, lsu_req_ready); end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();
        pulses = int'(lsu_rsp_valid) + int'(ifu_rsp_valid);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL stall_single_pulse: got %0d extra pulses expected 0", pulses); end
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0080;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777_7777;
        checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin errors++; $display("FAIL rstresp_cleared: got valid=%b addr=%h expected 0 0", mem_req_valid, mem_req_addr); end
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00 || {ifu_rsp_data, lsu_rsp_data} !== 64'h0) begin errors++; $display("FAIL rstresp_no_rsp: got valid=%b%b ifu_data=%h lsu_data=%h", ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data, lsu_rsp_data); end
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL rstresp_tie_ifu: got ifu=%b lsu=%b expected 1 0", ifu_req_ready, lsu_req_ready); end
        clear_inputs();
        tick();
        checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin errors++; $display("FAIL rstresp_late_quiet: got ifu=%b lsu=%b expected 0 0", ifu_rsp_valid, lsu_rsp_valid); end
    endtask

    task automatic test_spurious();
        do_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000 || {ifu_rsp_data, lsu_rsp_data} !== 64'h0) begin errors++; $display("FAIL spur_idle: got rsp=%b%b mem_valid=%b ifu_data=%h lsu_data=%h", ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_rsp_data, lsu_rsp_data); end
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0040;
        #1;
        checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL spur_idle_state: got ready=%b expected 1", ifu_req_ready); end
        tick();
        ifu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (mem_req_valid !== 1'b1 || {ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin errors++; $display("FAIL spur_req i=%0d: got mem_valid=%b rsp=%b%b expected 1 00", i, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid); end
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0FF0_0FF0;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h0FF0_0FF0 || lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL spur_real_rsp: got ifu=%b data=%h lsu=%b expected 1 0ff00ff0 0", ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid); end
        tick();
        checks++; if (ifu_rsp_valid !== 1'b0 || ifu_rsp_data !== 32'h0FF0_0FF0 || lsu_rsp_data !== 32'h0) begin errors++; $display("FAIL spur_hold: got ifu=%b ifu_data=%h lsu_data=%h", ifu_rsp_valid, ifu_rsp_data, lsu_rsp_data); end
    endtask

    // Reference model: each grant at cycle T with chosen waits rw/sw fixes the whole
    // schedule -- request visible T+1..T+1+rw, response driven at T+2+rw+sw, pulse
    // and next possible grant one cycle later.
    task automatic test_random(input int n_cycles);
        bit          have_txn;
        bit          own_lsu;
        bit          last_lsu;
        int          t_grant, t_req_end, t_rsp, t_pulse;
        int          rw, sw;
        logic [31:0] e_addr, e_wdata, e_ifu_data, e_lsu_data, pend_data;
        logic        e_wen;
        logic [3:0]  e_wmask;
        bit          e_mv, idle, e_ifu_rdy, e_lsu_rdy;
        do_reset();
        have_txn = 0; own_lsu = 0; last_lsu = 1;
        t_grant = -10; t_req_end = -10; t_rsp = -10; t_pulse = -10;
        e_addr = '0; e_wdata = '0; e_wen = 1'b0; e_wmask = '0;
        e_ifu_data = '0; e_lsu_data = '0; pend_data = '0;
        for (int c = 0; c < n_cycles; c++) begin
            if (c == t_pulse) begin
                if (own_lsu) e_lsu_data = pend_data;
                else         e_ifu_data = pend_data;
            end
            checks++; if (ifu_rsp_valid !== (c == t_pulse && !own_lsu) || lsu_rsp_valid !== (c == t_pulse && own_lsu)) begin errors++; $display("FAIL rand_rsp_valid c=%0d: got ifu=%b lsu=%b", c, ifu_rsp_valid, lsu_rsp_valid); end
            checks++; if (ifu_rsp_data !== e_ifu_data || lsu_rsp_data !== e_lsu_data) begin errors++; $display("FAIL rand_rsp_data c=%0d: got ifu=%h lsu=%h expected %h %h", c, ifu_rsp_data, lsu_rsp_data, e_ifu_data, e_lsu_data); end
            e_mv = have_txn && c > t_grant && c <= t_req_end;
            checks++; if (mem_req_valid !== e_mv) begin errors++; $display("FAIL rand_mem_valid c=%0d: got %b expected %b", c, mem_req_valid, e_mv); end
            checks++; if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {e_addr, e_wen, e_wdata, e_wmask}) begin errors++; $display("FAIL rand_mem_fields c=%0d: got %h %b %h %h expected %h %b %h %h", c, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, e_addr, e_wen, e_wdata, e_wmask); end
            ifu_req_valid = ($urandom_range(0, 9) < 6);
            ifu_req_addr  = $urandom;
            lsu_req_valid = ($urandom_range(0, 9) < 6);
            lsu_req_addr  = $urandom;
            lsu_req_wen   = 1'($urandom);
            lsu_req_wdata = $urandom;
            lsu_req_wmask = 4'($urandom);
            if (have_txn && c > t_grant && c <= t_req_end) mem_req_ready = (c == t_req_end);
            else                                            mem_req_ready = 1'($urandom);
            if (have_txn && c > t_req_end && c <= t_rsp)   mem_rsp_valid = (c == t_rsp);
            else                                            mem_rsp_valid = 1'($urandom);
            mem_rsp_data = $urandom;
            if (c == t_rsp) pend_data = mem_rsp_data;
            idle      = !have_txn || c >= t_pulse;
            e_ifu_rdy = idle && ifu_req_valid && (!lsu_req_valid || last_lsu);
            e_lsu_rdy = idle && lsu_req_valid && (!ifu_req_valid || !last_lsu);
            #1;
            checks++; if (ifu_req_ready !== e_ifu_rdy || lsu_req_ready !== e_lsu_rdy) begin errors++; $display("FAIL rand_ready c=%0d: got ifu=%b lsu=%b expected %b %b", c, ifu_req_ready, lsu_req_ready, e_ifu_rdy, e_lsu_rdy); end
            if (e_ifu_rdy || e_lsu_rdy) begin
                own_lsu  = e_lsu_rdy;
                last_lsu = e_lsu_rdy;
                e_addr   = own_lsu ? lsu_req_addr  : ifu_req_addr;
                e_wen    = own_lsu ? lsu_req_wen   : 1'b0;
                e_wdata  = own_lsu ? lsu_req_wdata : 32'h0;
                e_wmask  = own_lsu ? lsu_req_wmask : 4'h0;
                rw = $urandom_range(0, 3);
                sw = $urandom_range(0, 3);
                t_grant   = c;
                t_req_end = c + 1 + rw;
                t_rsp     = c + 2 + rw + sw;
                t_pulse   = t_rsp + 1;
                have_txn  = 1;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_store();
        test_stalls();
        test_reset_in_resp();
        test_spurious();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
